clkgen_multi: RTL and testbench
===============================

# clkgen_multi

Parametrised multi-channel clock-enable generator, the successor to the single-output fixed PLL wrapper. It derives NUM_CLOCKS independently divided, phase-offset channels from one reference clock. Each channel has a per-cycle enable pulse and a registered ~50 % square wave. A lock indication is asserted once all channels have been running aligned for a programmable settle time. It sits directly after the board reference clock and feeds every downstream block that needs a slower, phase-related strobe.

## Interface
- NUM_CLOCKS, 4: number of output channels, 1..8
- DIV_WIDTH, 8: width of divide and phase fields
- DEFAULT_DIV, 2: reset value of every channel divide ratio, 1..2^DIV_WIDTH-1
- LOCK_CYCLES, 16: cycles from restart to `locked`, ≥1
- refclk  in  1  sole clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  run request; low forces IDLE
- cfg_we  in  1  configuration write strobe, single cycle
- cfg_sel  in  max(1,$clog2(NUM_CLOCKS))  channel index for write
- cfg_div  in  DIV_WIDTH  divide ratio N
- cfg_phase  in  DIV_WIDTH  start delay in refclk cycles
- clk_en  out  NUM_CLOCKS  one-cycle enable pulse per channel period
- outclk  out  NUM_CLOCKS  registered square wave per channel
- locked  out  1  all channels aligned and settled

## Operation
- Per channel: div_i (reset DEFAULT_DIV), phase_i (reset 0), delay counter pd_i, period counter cnt_i (DIV_WIDTH bits).
- States: IDLE, SETTLE, LOCKED; reset state IDLE.
- IDLE: cnt/pd/settle counters 0, all outputs 0. When en is sampled 1, the state goes to SETTLE, pd_i <= phase_i, cnt_i <= 0, and the settle counter is cleared. This is a *restart*.
- SETTLE/LOCKED, per channel: if pd_i≠0, decrement; outputs for that channel 0. Else cnt_i <= (cnt_i==div_i-1) ? 0 : cnt_i+1.
- clk_en[i] = running_i && cnt_i==0.
- outclk[i] = running_i && cnt_i < ceil(div_i/2). For div_i=1, outclk is constant 1 while running.
- SETTLE: settle counter increments; at LOCK_CYCLES-1 the state goes to LOCKED.
- LOCKED: locked=1; channels keep running.
- en sampled 0 in SETTLE/LOCKED: next state IDLE; all outputs 0 from the next cycle.
- cfg_we with cfg_sel<NUM_CLOCKS: update div/phase of that channel at that edge.
  - cfg_div=0 is stored as 1. Any phase value is legal.
  - If the state is SETTLE/LOCKED (or en=1 is sampled in the same cycle), perform a restart of ALL channels using the new values. `locked` drops the next cycle.
- cfg_sel ≥ NUM_CLOCKS: write ignored, no restart.
- cfg_we and an en rise in the same cycle: a single restart using the newly written values.
- Asynchronous rst assertion at any time: immediately return to the reset state; configuration returns to defaults.

## Timing
- Reset values: clk_en=0, outclk=0, locked=0.
- Let S be the first cycle in SETTLE after a restart (the cycle after the sampling edge).
- clk_en[i] is high in cycles S+phase_i+k·div_i, for k≥0.
- outclk[i] is high in cycles S+phase_i+k·div_i+j, for 0≤j<ceil(div_i/2).
- locked is high from cycle S+LOCK_CYCLES until the cycle after a restart, an en=0 sample, or reset.
- All outputs are registered; no combinational path from inputs to outputs.
- Counter wrap: cnt_i wraps at div_i-1. A div_i change mid-run never produces an out-of-range cnt, because every write restarts the channels.

## Configuration
- CLKGEN_PHASE_EN defined: phase registers, pd_i counters and cfg_phase are functional as above.
- CLKGEN_PHASE_EN undefined:
  - cfg_phase is ignored and no phase registers or pd_i counters are synthesised.
  - Every channel behaves as phase_i=0, so all channels emit clk_en in cycle S.
- The div and lock behaviour is identical in both builds.

## Test plan
- Reset, en=1 with defaults (DEFAULT_DIV=2, LOCK_CYCLES=16) -> all clk_en pulse at S, S+2, S+4…; outclk high 1 cycle of 2; locked rises at S+16.
- Write ch1 div=5, phase=3 while LOCKED -> locked drops next cycle. ch1 clk_en at S+3, S+8, S+13; outclk[1] high 3 of 5 cycles; ch0 realigned to S. locked at S+16.
- Write cfg_div=0 to ch2, then en=1 -> ch2 clk_en and outclk constant 1 from S.
- cfg_sel=NUM_CLOCKS with cfg_we while LOCKED -> no register change, locked stays 1, waveforms uninterrupted.
- en dropped at LOCKED, reasserted 4 cycles later -> outputs 0 the cycle after the drop; fresh restart with locked again after 16 cycles. rst pulsed mid-SETTLE -> outputs 0 asynchronously and div restored to 2.
- Build without CLKGEN_PHASE_EN, write phase=7 to ch0 -> ch0 clk_en still at S, S+div.

Source files
------------

// File: rtl/clkgen_multi.sv
// rtl/clkgen_multi.sv - multi-channel divided clock-enable generator with lock indication
// Define CLKGEN_PHASE_EN to build the per-channel phase (start delay) registers.
module clkgen_multi #(
   parameter int NUM_CLOCKS  = 4,
   parameter int DIV_WIDTH   = 8,
   parameter int DEFAULT_DIV = 2,
   parameter int LOCK_CYCLES = 16,
   parameter int SEL_W       = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
   input  logic                  refclk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  cfg_we,
   input  logic [SEL_W-1:0]      cfg_sel,
   input  logic [DIV_WIDTH-1:0]  cfg_div,
   input  logic [DIV_WIDTH-1:0]  cfg_phase,
   output logic [NUM_CLOCKS-1:0] clk_en,
   output logic [NUM_CLOCKS-1:0] outclk,
   output logic                  locked
);

   localparam int SET_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_t;

   state_t               state, state_n;
   logic [SET_W-1:0]     settle_q, settle_n;
   logic [DIV_WIDTH-1:0] div_q [NUM_CLOCKS];
   logic [DIV_WIDTH-1:0] div_n [NUM_CLOCKS];
   logic [DIV_WIDTH-1:0] cnt_q [NUM_CLOCKS];
   logic [DIV_WIDTH-1:0] cnt_n [NUM_CLOCKS];
`ifdef CLKGEN_PHASE_EN
   logic [DIV_WIDTH-1:0] phase_q [NUM_CLOCKS];
   logic [DIV_WIDTH-1:0] phase_n [NUM_CLOCKS];
   logic [DIV_WIDTH-1:0] pd_q [NUM_CLOCKS];
   logic [DIV_WIDTH-1:0] pd_n [NUM_CLOCKS];
`else
   logic unused_phase;
   assign unused_phase = ^cfg_phase;
`endif
   logic [NUM_CLOCKS-1:0] run_n, clk_en_n, outclk_n;
   logic [DIV_WIDTH:0]    half;
   logic                  cfg_hit, restart;

   // Outputs are registered from next-state values so each cycle's pulse reflects that cycle's counters.
   always_comb begin
      cfg_hit  = cfg_we && (int'(cfg_sel) < NUM_CLOCKS);
      restart  = en && ((state == IDLE) || cfg_hit);
      state_n  = state;
      settle_n = settle_q;
      half     = '0;
      run_n    = '0;
      clk_en_n = '0;
      outclk_n = '0;
      if (!en) begin
         state_n  = IDLE;
         settle_n = '0;
      end else if (restart) begin
         state_n  = SETTLE;
         settle_n = '0;
      end else if (state == SETTLE) begin
         if (settle_q == SET_W'(LOCK_CYCLES - 1)) state_n = LOCKED;
         else settle_n = settle_q + SET_W'(1);
      end
      for (int i = 0; i < NUM_CLOCKS; i++) begin
         div_n[i] = div_q[i];
         cnt_n[i] = cnt_q[i];
`ifdef CLKGEN_PHASE_EN
         phase_n[i] = phase_q[i];
         pd_n[i]    = pd_q[i];
`endif
         if (cfg_hit && cfg_sel == SEL_W'(i)) begin
            div_n[i] = (cfg_div == '0) ? DIV_WIDTH'(1) : cfg_div;
`ifdef CLKGEN_PHASE_EN
            phase_n[i] = cfg_phase;
`endif
         end
         if (state_n == IDLE) begin
            cnt_n[i] = '0;
`ifdef CLKGEN_PHASE_EN
            pd_n[i]  = '0;
`endif
         end else if (restart) begin
            cnt_n[i] = '0;
`ifdef CLKGEN_PHASE_EN
            pd_n[i]  = phase_n[i];
         end else if (pd_q[i] != '0) begin
            pd_n[i]  = pd_q[i] - DIV_WIDTH'(1);
`endif
         end else begin
            cnt_n[i] = (cnt_q[i] == div_q[i] - DIV_WIDTH'(1)) ? '0 : cnt_q[i] + DIV_WIDTH'(1);
         end
         run_n[i] = (state_n != IDLE);
`ifdef CLKGEN_PHASE_EN
         run_n[i] = run_n[i] && (pd_n[i] == '0);
`endif
         half        = ({1'b0, div_n[i]} + (DIV_WIDTH+1)'(1)) >> 1;
         clk_en_n[i] = run_n[i] && (cnt_n[i] == '0);
         outclk_n[i] = run_n[i] && ({1'b0, cnt_n[i]} < half);
      end
   end

   always_ff @(posedge refclk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         settle_q <= '0;
         clk_en   <= '0;
         outclk   <= '0;
         locked   <= 1'b0;
         for (int i = 0; i < NUM_CLOCKS; i++) begin
            div_q[i] <= DIV_WIDTH'(DEFAULT_DIV);
            cnt_q[i] <= '0;
`ifdef CLKGEN_PHASE_EN
            phase_q[i] <= '0;
            pd_q[i]    <= '0;
`endif
         end
      end else begin
         state    <= state_n;
         settle_q <= settle_n;
         clk_en   <= clk_en_n;
         outclk   <= outclk_n;
         locked   <= (state_n == LOCKED);
         for (int i = 0; i < NUM_CLOCKS; i++) begin
            div_q[i] <= div_n[i];
            cnt_q[i] <= cnt_n[i];
`ifdef CLKGEN_PHASE_EN
            phase_q[i] <= phase_n[i];
            pd_q[i]    <= pd_n[i];
`endif
         end
      end
   end

endmodule

// File: tb/tb_clkgen_multi.sv
// tb/tb_clkgen_multi.sv - directed self-checking bench for clkgen_multi (three channels)
module tb_clkgen_multi;

`ifdef CLKGEN_PHASE_EN
   localparam bit PHASE_ON = 1'b1;
`else
   localparam bit PHASE_ON = 1'b0;
`endif

   logic       refclk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic       cfg_we = 1'b0;
   logic [1:0] cfg_sel = '0;
   logic [7:0] cfg_div = '0;
   logic [7:0] cfg_phase = '0;
   logic [2:0] clk_en, outclk;
   logic       locked;

   int vectors = 0;
   int miscompares = 0;
   int t = 0;
   int dv [3] = '{2, 2, 2};
   int ph [3] = '{0, 0, 0};

   clkgen_multi #(.NUM_CLOCKS(3), .DIV_WIDTH(8), .DEFAULT_DIV(2), .LOCK_CYCLES(16)) dut (
      .refclk(refclk), .rst(rst), .en(en), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
      .cfg_div(cfg_div), .cfg_phase(cfg_phase), .clk_en(clk_en), .outclk(outclk), .locked(locked)
   );

   always #5 refclk = ~refclk;

   // Expected waveforms from the timing formulas, t counted from the first SETTLE cycle.
   function automatic logic [2:0] exp_en(input int tt);
      logic [2:0] r = '0;
      for (int i = 0; i < 3; i++) r[i] = (tt >= ph[i]) && (((tt - ph[i]) % dv[i]) == 0);
      return r;
   endfunction

   function automatic logic [2:0] exp_oc(input int tt);
      logic [2:0] r = '0;
      for (int i = 0; i < 3; i++) r[i] = (tt >= ph[i]) && (((tt - ph[i]) % dv[i]) < (dv[i] + 1) / 2);
      return r;
   endfunction

   function automatic int eph(input int p);
      return PHASE_ON ? p : 0;
   endfunction

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(negedge refclk);
      vectors += 3;
      if (clk_en !== 3'b000) begin miscompares++; $display("FAIL reset clk_en got %b exp 000", clk_en); end
      if (outclk !== 3'b000) begin miscompares++; $display("FAIL reset outclk got %b exp 000", outclk); end
      if (locked !== 1'b0)   begin miscompares++; $display("FAIL reset locked got %b exp 0", locked); end
   endtask

   task automatic test_defaults();
      rst = 1'b1; en = 1'b1; t = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge refclk);
         vectors += 3;
         if (clk_en !== exp_en(t)) begin miscompares++; $display("FAIL defaults t=%0d clk_en got %b exp %b", t, clk_en, exp_en(t)); end
         if (outclk !== exp_oc(t)) begin miscompares++; $display("FAIL defaults t=%0d outclk got %b exp %b", t, outclk, exp_oc(t)); end
         if (locked !== (t >= 16)) begin miscompares++; $display("FAIL defaults t=%0d locked got %b", t, locked); end
         t++;
      end
   endtask

   task automatic test_phase_write();
      cfg_we = 1'b1; cfg_sel = 2'd1; cfg_div = 8'd5; cfg_phase = 8'd3;
      dv[1] = 5; ph[1] = eph(3); t = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge refclk);
         cfg_we = 1'b0;
         vectors += 3;
         if (clk_en !== exp_en(t)) begin miscompares++; $display("FAIL phase_write t=%0d clk_en got %b exp %b", t, clk_en, exp_en(t)); end
         if (outclk !== exp_oc(t)) begin miscompares++; $display("FAIL phase_write t=%0d outclk got %b exp %b", t, outclk, exp_oc(t)); end
         if (locked !== (t >= 16)) begin miscompares++; $display("FAIL phase_write t=%0d locked got %b", t, locked); end
         t++;
      end
   endtask

   task automatic test_bad_sel();
      cfg_we = 1'b1; cfg_sel = 2'd3; cfg_div = 8'd7; cfg_phase = 8'd1;
      for (int k = 0; k < 10; k++) begin
         @(negedge refclk);
         cfg_we = 1'b0;
         vectors += 3;
         if (clk_en !== exp_en(t)) begin miscompares++; $display("FAIL bad_sel t=%0d clk_en got %b exp %b", t, clk_en, exp_en(t)); end
         if (outclk !== exp_oc(t)) begin miscompares++; $display("FAIL bad_sel t=%0d outclk got %b exp %b", t, outclk, exp_oc(t)); end
         if (locked !== 1'b1)      begin miscompares++; $display("FAIL bad_sel t=%0d locked got %b exp 1", t, locked); end
         t++;
      end
   endtask

   task automatic test_en_drop();
      en = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge refclk);
         vectors += 3;
         if (clk_en !== 3'b000) begin miscompares++; $display("FAIL en_drop idle%0d clk_en got %b exp 000", k, clk_en); end
         if (outclk !== 3'b000) begin miscompares++; $display("FAIL en_drop idle%0d outclk got %b exp 000", k, outclk); end
         if (locked !== 1'b0)   begin miscompares++; $display("FAIL en_drop idle%0d locked got %b exp 0", k, locked); end
      end
      en = 1'b1; t = 0;
      for (int k = 0; k < 18; k++) begin
         @(negedge refclk);
         vectors += 3;
         if (clk_en !== exp_en(t)) begin miscompares++; $display("FAIL en_restart t=%0d clk_en got %b exp %b", t, clk_en, exp_en(t)); end
         if (outclk !== exp_oc(t)) begin miscompares++; $display("FAIL en_restart t=%0d outclk got %b exp %b", t, outclk, exp_oc(t)); end
         if (locked !== (t >= 16)) begin miscompares++; $display("FAIL en_restart t=%0d locked got %b", t, locked); end
         t++;
      end
   endtask

   task automatic test_div_zero();
      en = 1'b0;
      repeat (2) @(negedge refclk);
      en = 1'b1; cfg_we = 1'b1; cfg_sel = 2'd2; cfg_div = 8'd0; cfg_phase = 8'd0;
      dv[2] = 1; ph[2] = 0; t = 0;
      for (int k = 0; k < 18; k++) begin
         @(negedge refclk);
         cfg_we = 1'b0;
         vectors += 3;
         if (clk_en !== exp_en(t)) begin miscompares++; $display("FAIL div_zero t=%0d clk_en got %b exp %b", t, clk_en, exp_en(t)); end
         if (outclk !== exp_oc(t)) begin miscompares++; $display("FAIL div_zero t=%0d outclk got %b exp %b", t, outclk, exp_oc(t)); end
         if (locked !== (t >= 16)) begin miscompares++; $display("FAIL div_zero t=%0d locked got %b", t, locked); end
         t++;
      end
   endtask

   task automatic test_rst_mid_settle();
      cfg_we = 1'b1; cfg_sel = 2'd0; cfg_div = 8'd4; cfg_phase = 8'd0;
      dv[0] = 4; ph[0] = 0; t = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge refclk);
         cfg_we = 1'b0;
         vectors += 2;
         if (clk_en !== exp_en(t)) begin miscompares++; $display("FAIL rst_settle t=%0d clk_en got %b exp %b", t, clk_en, exp_en(t)); end
         if (locked !== 1'b0)      begin miscompares++; $display("FAIL rst_settle t=%0d locked got %b exp 0", t, locked); end
         t++;
      end
      #2 rst = 1'b0;
      #1;
      vectors += 3;
      if (clk_en !== 3'b000) begin miscompares++; $display("FAIL async_rst clk_en got %b exp 000", clk_en); end
      if (outclk !== 3'b000) begin miscompares++; $display("FAIL async_rst outclk got %b exp 000", outclk); end
      if (locked !== 1'b0)   begin miscompares++; $display("FAIL async_rst locked got %b exp 0", locked); end
      @(negedge refclk);
      rst = 1'b1;
      dv = '{2, 2, 2}; ph = '{0, 0, 0}; t = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge refclk);
         vectors += 2;
         if (clk_en !== exp_en(t)) begin miscompares++; $display("FAIL rst_defaults t=%0d clk_en got %b exp %b", t, clk_en, exp_en(t)); end
         if (outclk !== exp_oc(t)) begin miscompares++; $display("FAIL rst_defaults t=%0d outclk got %b exp %b", t, outclk, exp_oc(t)); end
         t++;
      end
   endtask

   task automatic test_phase_ignored();
      cfg_we = 1'b1; cfg_sel = 2'd0; cfg_div = 8'd3; cfg_phase = 8'd7;
      dv[0] = 3; ph[0] = eph(7); t = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge refclk);
         cfg_we = 1'b0;
         vectors += 2;
         if (clk_en !== exp_en(t)) begin miscompares++; $display("FAIL phase_cfg t=%0d clk_en got %b exp %b", t, clk_en, exp_en(t)); end
         if (outclk !== exp_oc(t)) begin miscompares++; $display("FAIL phase_cfg t=%0d outclk got %b exp %b", t, outclk, exp_oc(t)); end
         t++;
      end
   endtask

   initial begin
      test_reset();
      test_defaults();
      test_phase_write();
      test_bad_sel();
      test_en_drop();
      test_div_zero();
      test_rst_mid_settle();
      test_phase_ignored();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
